// File: rtl/vcop_pkg.sv
// Shared encodings, queue entry layout and decode helpers for the vector
// coprocessor execution core.
package vcop_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] FUNCT7_VADD    = 7'h00;
    localparam logic [6:0] FUNCT7_VSUB    = 7'h01;
    localparam logic [6:0] FUNCT7_VMUL    = 7'h02;
    localparam logic [6:0] FUNCT7_VMAC    = 7'h03;

    typedef enum logic [1:0] {
        OP_VADD,
        OP_VSUB,
        OP_VMUL,
        OP_VMAC
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESULT
    } state_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       committed;
        logic       killed;
    } q_entry_t;

    function automatic logic is_vop(input logic [31:0] instr);
        logic [6:0] f7;
        f7 = instr[31:25];
        return (instr[6:0] == OPCODE_CUSTOM0) &&
               ((f7 == FUNCT7_VADD) || (f7 == FUNCT7_VSUB) ||
                (f7 == FUNCT7_VMUL) || (f7 == FUNCT7_VMAC));
    endfunction

    function automatic op_e funct7_to_op(input logic [6:0] f7);
        case (f7)
            FUNCT7_VSUB: return OP_VSUB;
            FUNCT7_VMUL: return OP_VMUL;
            FUNCT7_VMAC: return OP_VMAC;
            default:     return OP_VADD;
        endcase
    endfunction

endpackage

// File: rtl/vcop_lane_alu.sv
// One element lane: add, subtract, multiply or multiply-accumulate with
// unsigned wrap at ELEN bits.
module vcop_lane_alu
    import vcop_pkg::*;
#(
    parameter int ELEN = 32
) (
    input  logic [ELEN-1:0] a,
    input  logic [ELEN-1:0] b,
    input  logic [ELEN-1:0] c,
    input  op_e             op,
    output logic [ELEN-1:0] y
);

    logic [ELEN-1:0] prod;

    assign prod = a * b;

    always_comb begin
        y = '0;
        case (op)
            OP_VADD: y = a + b;
            OP_VSUB: y = a - b;
            OP_VMUL: y = prod;
            OP_VMAC: y = prod + c;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vcop_exec_core.sv
// X-IF vector coprocessor core: in-order speculative issue queue with
// commit/kill, multi-beat lane execution and an internal vector register file.
module vcop_exec_core
    import vcop_pkg::*;
#(
    parameter int VLEN       = 256,
    parameter int ELEN       = 32,
    parameter int NUM_LANES  = 4,
    parameter int QDEPTH     = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int NUM_VREGS  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [31:0]                  issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]        issue_id_i,
    output logic                         issue_accept_o,
    input  logic                         commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]        commit_id_i,
    input  logic                         commit_kill_i,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [X_ID_WIDTH-1:0]        result_id_o,
    output logic [4:0]                   result_rd_o,
    output logic                         busy_o,
    input  logic                         dbg_we_i,
    input  logic [$clog2(NUM_VREGS)-1:0] dbg_waddr_i,
    input  logic [VLEN-1:0]              dbg_wdata_i,
    input  logic [$clog2(NUM_VREGS)-1:0] dbg_raddr_i,
    output logic [VLEN-1:0]              dbg_rdata_o
);

    localparam int NUM_BEATS = VLEN / (ELEN * NUM_LANES);
    localparam int SLICE_W   = ELEN * NUM_LANES;
    localparam int PTR_W     = $clog2(QDEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    q_entry_t                q_ent [QDEPTH];
    logic [X_ID_WIDTH-1:0]   q_id  [QDEPTH];
    logic [PTR_W-1:0]        head_q, tail_q;
    logic [CNT_W-1:0]        count_q;
    logic [QDEPTH-1:0]       slot_vld;
    q_entry_t                head, new_ent;
    logic                    push, pop, exec_we;

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q;

    logic [VLEN-1:0]         vrf [NUM_VREGS];
    logic [31:0]             beat_off;
    logic [SLICE_W-1:0]      s1, s2, sd, sy;
    op_e                     cur_op;

    assign head           = q_ent[head_q];
    assign issue_accept_o = is_vop(issue_instr_i);
    assign issue_ready_o  = (count_q != CNT_W'(QDEPTH));
    assign push           = issue_valid_i && issue_ready_o && issue_accept_o;

    // A commit naming the id being enqueued this cycle lands in the new entry.
    always_comb begin
        new_ent           = '0;
        new_ent.funct7    = issue_instr_i[31:25];
        new_ent.rd        = issue_instr_i[11:7];
        new_ent.rs1       = issue_instr_i[19:15];
        new_ent.rs2       = issue_instr_i[24:20];
        new_ent.committed = commit_valid_i && (commit_id_i == issue_id_i);
        new_ent.killed    = commit_valid_i && (commit_id_i == issue_id_i) && commit_kill_i;
    end

    always_comb begin
        logic [PTR_W-1:0] off;
        slot_vld = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            off         = PTR_W'(i) - head_q;
            slot_vld[i] = ({1'b0, off} < count_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_ent[i] <= '0;
                q_id[i]  <= '0;
            end
        end else begin
            if (commit_valid_i) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (slot_vld[i] && !q_ent[i].committed && (q_id[i] == commit_id_i)) begin
                        q_ent[i].committed <= 1'b1;
                        q_ent[i].killed    <= commit_kill_i;
                    end
                end
            end
            if (push) begin
                q_ent[tail_q] <= new_ent;
                q_id[tail_q]  <= issue_id_i;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        exec_we        = 1'b0;
        result_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && head.committed) begin
                    if (head.killed) pop = 1'b1;
                    else             state_d = EXEC;
                end
            end
            EXEC: begin
                exec_we = 1'b1;
                if (beat_q == BEAT_W'(NUM_BEATS - 1)) state_d = RESULT;
            end
            RESULT: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= (state_q == EXEC) ? beat_q + 1'b1 : '0;
        end
    end

    assign result_id_o = result_valid_o ? q_id[head_q] : '0;
    assign result_rd_o = result_valid_o ? head.rd : '0;
    assign busy_o      = (count_q != '0) || (state_q != IDLE);

    // Each beat reads and writes only its own element slice, so rd == rs is safe.
    assign beat_off = 32'(beat_q) * 32'(SLICE_W);
    assign s1       = vrf[head.rs1][beat_off +: SLICE_W];
    assign s2       = vrf[head.rs2][beat_off +: SLICE_W];
    assign sd       = vrf[head.rd][beat_off +: SLICE_W];
    assign cur_op   = funct7_to_op(head.funct7);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vcop_lane_alu #(.ELEN(ELEN)) u_alu (
            .a  (s1[l*ELEN +: ELEN]),
            .b  (s2[l*ELEN +: ELEN]),
            .c  (sd[l*ELEN +: ELEN]),
            .op (cur_op),
            .y  (sy[l*ELEN +: ELEN])
        );
    end

    // The execution write follows the preload write so it wins on a collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_VREGS; r++) vrf[r] <= '0;
        end else begin
            if (dbg_we_i) vrf[dbg_waddr_i] <= dbg_wdata_i;
            if (exec_we)  vrf[head.rd][beat_off +: SLICE_W] <= sy;
        end
    end

    assign dbg_rdata_o = vrf[dbg_raddr_i];

endmodule

// File: tb/tb_vcop_exec_core.sv
// Bench for vcop_exec_core: scenario tasks driving X-IF issue/commit and a
// result scoreboard fed by an expected-{id,rd} queue.
module tb_vcop_exec_core;

    localparam int VLEN = 256;
    localparam int ELEN = 32;
    localparam int NL   = 4;
    localparam int QD   = 4;
    localparam int IDW  = 4;
    localparam int NV   = 32;
    localparam int NE   = VLEN / ELEN;

    logic             clk_i, rst_ni;
    logic             issue_valid_i, issue_ready_o, issue_accept_o;
    logic [31:0]      issue_instr_i;
    logic [IDW-1:0]   issue_id_i, commit_id_i, result_id_o;
    logic             commit_valid_i, commit_kill_i;
    logic             result_valid_o, result_ready_i, busy_o;
    logic [4:0]       result_rd_o;
    logic             dbg_we_i;
    logic [4:0]       dbg_waddr_i, dbg_raddr_i;
    logic [VLEN-1:0]  dbg_wdata_i, dbg_rdata_o;

    int errors = 0;
    int checks = 0;
    logic [IDW+4:0] exp_q[$];

    vcop_exec_core #(
        .VLEN(VLEN), .ELEN(ELEN), .NUM_LANES(NL), .QDEPTH(QD),
        .X_ID_WIDTH(IDW), .NUM_VREGS(NV)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_accept_o(issue_accept_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o),
        .busy_o(busy_o),
        .dbg_we_i(dbg_we_i), .dbg_waddr_i(dbg_waddr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_raddr_i(dbg_raddr_i), .dbg_rdata_o(dbg_rdata_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0001011};
    endfunction

    function automatic logic [VLEN-1:0] splat(input logic [31:0] e);
        logic [VLEN-1:0] v;
        for (int i = 0; i < NE; i++) v[i*ELEN +: ELEN] = e;
        return v;
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return p[31:0];
            default: return p[31:0] + c;
        endcase
    endfunction

    // driver tasks
    task automatic preload(input logic [4:0] addr, input logic [VLEN-1:0] data);
        @(posedge clk_i); #1;
        dbg_we_i = 1'b1; dbg_waddr_i = addr; dbg_wdata_i = data;
        @(posedge clk_i); #1;
        dbg_we_i = 1'b0;
    endtask

    task automatic vread(input logic [4:0] addr, output logic [VLEN-1:0] data);
        dbg_raddr_i = addr;
        #1;
        data = dbg_rdata_o;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [IDW-1:0] id,
                         output logic acc, output logic rdy);
        @(posedge clk_i); #1;
        issue_valid_i = 1'b1; issue_instr_i = instr; issue_id_i = id;
        @(negedge clk_i);
        acc = issue_accept_o;
        rdy = issue_ready_o;
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0;
    endtask

    task automatic commit(input logic [IDW-1:0] id, input logic [4:0] rd, input logic kill);
        @(posedge clk_i); #1;
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
        if (!kill) exp_q.push_back({id, rd});
        @(posedge clk_i); #1;
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk_i);
            if (!busy_o) break;
        end
        if (n == budget) begin
            checks++; errors++;
            $display("FAIL %s_timeout: busy_o still 1 after %0d cycles, required 0", name, budget);
        end
    endtask

    // scoreboard
    always @(negedge clk_i) begin
        if (rst_ni && result_valid_o && result_ready_i) begin
            logic [IDW+4:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got id=%0d rd=%0d, required no result",
                         result_id_o, result_rd_o);
            end else begin
                e = exp_q.pop_front();
                if ({result_id_o, result_rd_o} !== e) begin
                    errors++;
                    $display("FAIL result_order: got id=%0d rd=%0d, required id=%0d rd=%0d",
                             result_id_o, result_rd_o, e[IDW+4:5], e[4:0]);
                end
            end
        end
    end

    task automatic test_reset();
        logic [VLEN-1:0] d;
        rst_ni = 1'b0;
        issue_valid_i = 1'b0; issue_instr_i = '0; issue_id_i = '0;
        commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
        result_ready_i = 1'b1; dbg_we_i = 1'b0; dbg_waddr_i = '0;
        dbg_wdata_i = '0; dbg_raddr_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", result_valid_o); end
        checks++; if (result_id_o !== '0) begin errors++; $display("FAIL reset_id: got %0d required 0", result_id_o); end
        checks++; if (result_rd_o !== '0) begin errors++; $display("FAIL reset_rd: got %0d required 0", result_rd_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy_o); end
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", issue_ready_o); end
        vread(5'd9, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL reset_vrf: got %h required 0", d); end
    endtask

    task automatic test_vmac();
        logic acc, rdy;
        logic [VLEN-1:0] d;
        int lat;
        preload(5'd1, splat(32'd3));
        preload(5'd2, splat(32'd5));
        preload(5'd3, splat(32'd7));
        issue(mk(7'h03, 5'd3, 5'd1, 5'd2), 4'd2, acc, rdy);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL vmac_accept: got %0b required 1", acc); end
        commit(4'd2, 5'd3, 1'b0);
        // First negedge after the commit edge is the IDLE cycle seeing the flag,
        // so with two beats the result appears on the fourth negedge.
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            if (result_valid_o) begin lat = k; break; end
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL vmac_latency: got %0d negedges required 4", lat); end
        wait_idle(20, "vmac");
        vread(5'd3, d);
        checks++; if (d !== splat(32'd22)) begin errors++; $display("FAIL vmac_data: got %h required %h", d, splat(32'd22)); end
    endtask

    task automatic test_add_sub();
        logic acc, rdy;
        logic [VLEN-1:0] d;
        preload(5'd1, splat(32'hFFFF_FFFF));
        preload(5'd2, splat(32'd2));
        issue(mk(7'h00, 5'd4, 5'd1, 5'd2), 4'd3, acc, rdy);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL vadd_accept: got %0b required 1", acc); end
        issue(mk(7'h01, 5'd5, 5'd2, 5'd1), 4'd4, acc, rdy);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL vsub_accept: got %0b required 1", acc); end
        commit(4'd3, 5'd4, 1'b0);
        commit(4'd4, 5'd5, 1'b0);
        wait_idle(30, "addsub");
        vread(5'd4, d);
        checks++; if (d !== splat(32'd1)) begin errors++; $display("FAIL vadd_data: got %h required %h", d, splat(32'd1)); end
        vread(5'd5, d);
        checks++; if (d !== splat(32'd3)) begin errors++; $display("FAIL vsub_data: got %h required %h", d, splat(32'd3)); end
    endtask

    task automatic test_kill();
        logic acc, rdy;
        logic [VLEN-1:0] d;
        preload(5'd6, splat(32'hA5A5_0F0F));
        issue(mk(7'h00, 5'd6, 5'd1, 5'd2), 4'd1, acc, rdy);
        commit(4'd1, 5'd6, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            if (!busy_o) break;
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL kill_busy: got %0b required 0 within 2 cycles", busy_o); end
        repeat (4) @(negedge clk_i);
        vread(5'd6, d);
        checks++; if (d !== splat(32'hA5A5_0F0F)) begin errors++; $display("FAIL kill_data: got %h required %h", d, splat(32'hA5A5_0F0F)); end
    endtask

    task automatic test_back_to_back();
        logic acc, rdy;
        logic [VLEN-1:0] d;
        for (int i = 0; i < 4; i++) begin
            issue(mk(7'h00, 5'(7 + i), 5'd1, 5'd2), 4'(i), acc, rdy);
            checks++; if (!(acc === 1'b1 && rdy === 1'b1)) begin errors++; $display("FAIL fill_issue%0d: got accept=%0b ready=%0b required 1/1", i, acc, rdy); end
        end
        issue(mk(7'h00, 5'd14, 5'd1, 5'd2), 4'd4, acc, rdy);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b required 0", rdy); end
        for (int i = 0; i < 4; i++) commit(4'(i), 5'(7 + i), 1'b0);
        wait_idle(100, "b2b");
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending results required 0", exp_q.size()); end
        vread(5'd10, d);
        checks++; if (d !== splat(32'd1)) begin errors++; $display("FAIL b2b_data: got %h required %h", d, splat(32'd1)); end
        vread(5'd14, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL b2b_dropped: got %h required 0", d); end
    endtask

    task automatic test_backpressure();
        logic acc, rdy;
        logic [VLEN-1:0] d;
        int n;
        result_ready_i = 1'b0;
        preload(5'd12, splat(32'h1234_5678));
        issue(mk(7'h00, 5'd11, 5'd1, 5'd2), 4'd5, acc, rdy);
        issue(mk(7'h02, 5'd12, 5'd1, 5'd2), 4'd6, acc, rdy);
        commit(4'd5, 5'd11, 1'b0);
        commit(4'd6, 5'd12, 1'b0);
        for (n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (result_valid_o) break;
        end
        checks++; if (n == 20) begin errors++; $display("FAIL bp_timeout: result_valid_o 0 after 20 cycles, required 1"); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %0b required 1", k, result_valid_o); end
            checks++; if (result_id_o !== 4'd5) begin errors++; $display("FAIL bp_id%0d: got %0d required 5", k, result_id_o); end
            checks++; if (result_rd_o !== 5'd11) begin errors++; $display("FAIL bp_rd%0d: got %0d required 11", k, result_rd_o); end
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_busy%0d: got %0b required 1", k, busy_o); end
        end
        vread(5'd12, d);
        checks++; if (d !== splat(32'h1234_5678)) begin errors++; $display("FAIL bp_held: got %h required %h", d, splat(32'h1234_5678)); end
        @(posedge clk_i); #1;
        result_ready_i = 1'b1;
        wait_idle(40, "bp");
        vread(5'd11, d);
        checks++; if (d !== splat(32'd1)) begin errors++; $display("FAIL bp_vadd: got %h required %h", d, splat(32'd1)); end
        vread(5'd12, d);
        checks++; if (d !== splat(32'hFFFF_FFFE)) begin errors++; $display("FAIL bp_vmul: got %h required %h", d, splat(32'hFFFF_FFFE)); end
    endtask

    task automatic test_random_ops();
        logic acc, rdy;
        logic [VLEN-1:0] va, vb, vc, expv, d;
        logic [1:0] op;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NE; i++) begin
                va[i*ELEN +: ELEN] = $urandom;
                vb[i*ELEN +: ELEN] = $urandom;
                vc[i*ELEN +: ELEN] = $urandom;
            end
            op = 2'($urandom_range(0, 3));
            preload(5'd20, va);
            preload(5'd21, vb);
            preload(5'd22, vc);
            for (int i = 0; i < NE; i++)
                expv[i*ELEN +: ELEN] = model(op, va[i*ELEN +: ELEN], vb[i*ELEN +: ELEN], vc[i*ELEN +: ELEN]);
            issue(mk({5'd0, op}, 5'd22, 5'd20, 5'd21), 4'(8 + it), acc, rdy);
            commit(4'(8 + it), 5'd22, 1'b0);
            wait_idle(30, "rand");
            vread(5'd22, d);
            checks++; if (d !== expv) begin errors++; $display("FAIL rand_op%0d_%0d: got %h required %h", it, op, d, expv); end
        end
    endtask

    task automatic test_illegal_and_reset();
        logic acc, rdy;
        logic [VLEN-1:0] d;
        issue(mk(7'h7F, 5'd15, 5'd1, 5'd2), 4'd9, acc, rdy);
        checks++; if (acc !== 1'b0) begin errors++; $display("FAIL illegal_funct7: got accept=%0b required 0", acc); end
        issue({7'h00, 5'd2, 5'd1, 3'b000, 5'd15, 7'b0110011}, 4'd9, acc, rdy);
        checks++; if (acc !== 1'b0) begin errors++; $display("FAIL illegal_opcode: got accept=%0b required 0", acc); end
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL illegal_count: got busy=%0b required 0", busy_o); end
        issue(mk(7'h00, 5'd13, 5'd1, 5'd2), 4'd10, acc, rdy);
        commit(4'd10, 5'd13, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b required 0", result_valid_o); end
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b required 1", issue_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", busy_o); end
        vread(5'd1, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL rst_v1: got %h required 0", d); end
        vread(5'd13, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL rst_v13: got %h required 0", d); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rst_no_result: got %0b required 0", result_valid_o); end
    endtask

    initial begin
        test_reset();
        test_vmac();
        test_add_sub();
        test_kill();
        test_back_to_back();
        test_backpressure();
        test_random_ops();
        test_illegal_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
